wallace_mul_seq_ctrl: RTL and testbench

// - Sequencer that computes a WIDTH x WIDTH unsigned product using one shared 4x4 Wallace multiplier.
// - Splits operands into 4-bit chunks, drives each chunk pair into the multiplier, and accumulates

---
 rtl/wallace_mul_seq_ctrl.sv | 115 +++++++++++
 tb/tb_wallace_mul_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wallace_mul_seq_ctrl.sv
// Sequential WIDTHxWIDTH unsigned multiplier that time-shares an external 4x4 multiplier.
// Define MUL_ZERO_SKIP_EN to skip chunk pairs with a zero operand chunk.
module wallace_mul_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy,
    output logic [3:0]         mul_a,
    output logic [3:0]         mul_b,
    input  logic [7:0]         mul_p
);

    localparam int unsigned CHUNKS = WIDTH / 4;
    localparam int unsigned IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     a_r, b_r;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   pp;
    logic [IW-1:0]        i, j;
    logic [IW-1:0]        nxt_i, nxt_j;
    logic                 nxt_found;
    logic                 usable;
    int unsigned          start;
`ifdef MUL_ZERO_SKIP_EN
    logic [WIDTH-1:0]     sel_a, sel_b;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_p     = acc;
    assign mul_a     = (state == CALC) ? a_r[4*i +: 4] : 4'd0;
    assign mul_b     = (state == CALC) ? b_r[4*j +: 4] : 4'd0;
    assign pp        = (2*WIDTH)'(mul_p) << (4 * (32'(i) + 32'(j)));

    // Pair search: first (i,j) in j-inner order at or after 'start'. In IDLE the
    // search looks at the incoming operands so the first pair is ready on accept.
    always_comb begin
        state_next = state;
        start      = 0;
        nxt_found  = 1'b0;
        nxt_i      = '0;
        nxt_j      = '0;
        usable     = 1'b0;
`ifdef MUL_ZERO_SKIP_EN
        sel_a = (state == IDLE) ? in_a : a_r;
        sel_b = (state == IDLE) ? in_b : b_r;
`endif
        if (state == CALC)
            start = 32'(i) * CHUNKS + 32'(j) + 1;
        for (int unsigned ii = 0; ii < CHUNKS; ii++) begin
            for (int unsigned jj = 0; jj < CHUNKS; jj++) begin
`ifdef MUL_ZERO_SKIP_EN
                usable = (sel_a[4*ii +: 4] != 4'd0) && (sel_b[4*jj +: 4] != 4'd0);
`else
                usable = 1'b1;
`endif
                if (!nxt_found && usable && (ii * CHUNKS + jj >= start)) begin
                    nxt_found = 1'b1;
                    nxt_i     = IW'(ii);
                    nxt_j     = IW'(jj);
                end
            end
        end

        case (state)
            IDLE: if (in_valid) state_next = nxt_found ? CALC : DONE;
            CALC: if (!nxt_found) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= in_a;
                        b_r <= in_b;
                        acc <= '0;
                        i   <= nxt_i;
                        j   <= nxt_j;
                    end
                end
                CALC: begin
                    acc <= acc + pp;
                    i   <= nxt_i;
                    j   <= nxt_j;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_mul_seq_ctrl.sv
// Self-checking bench for wallace_mul_seq_ctrl (WIDTH=8), both MUL_ZERO_SKIP_EN builds.
module tb_wallace_mul_seq_ctrl;

    localparam int W      = 8;
    localparam int CHUNKS = W / 4;
`ifdef MUL_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a, in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           busy;
    logic [3:0]     mul_a, mul_b;
    logic [7:0]     mul_p;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Stand-in for the external 4x4 multiplier
    assign mul_p = 8'(mul_a) * 8'(mul_b);

    wallace_mul_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        int             lat;
        int             hold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edges from the accept edge (inclusive) to out_valid: one per useful pair, plus one.
    function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        for (int x = 0; x < CHUNKS; x++)
            for (int y = 0; y < CHUNKS; y++)
                if (!SKIP || (((a >> (4*x)) & 15) != 0 && ((b >> (4*y)) & 15) != 0))
                    n++;
        return n + 1;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v = '0;
        for (int k = 0; k < CHUNKS; k++)
            if ($urandom_range(0, 3) != 0)
                v[4*k +: 4] = 4'($urandom_range(1, 15));
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp_p, input int exp_lat, input int hold);
        int lat;
        check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        check({tag, " mul_a idle"}, 64'({mul_a, mul_b}), 64'd0);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " out_p"}, 64'(out_p), 64'(exp_p));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            @(negedge clk);
            check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold out_p"}, 64'(out_p), 64'(exp_p));
            check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        check({tag, " busy drop"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h12, 8'h34, 16'h03A8, 5,              0};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 5,              1};
        vecs[2] = '{8'h00, 8'hAB, 16'h0000, SKIP ? 1 : 5,   0};
        vecs[3] = '{8'h10, 8'h01, 16'h0010, SKIP ? 2 : 5,   2};
        vecs[4] = '{8'h00, 8'h00, 16'h0000, SKIP ? 1 : 5,   0};
        vecs[5] = '{8'h03, 8'h05, 16'h000F, SKIP ? 2 : 5,   0};
        vecs[6] = '{8'h12, 8'h34, 16'h03A8, 5,             10};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_p", 64'(out_p), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset mul_ab", 64'({mul_a, mul_b}), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[k])
            run_txn($sformatf("vec%0d", k), vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].lat, vecs[k].hold);

        // Reset during the second CALC cycle discards the operation
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midcalc busy", 64'(busy), 64'd1);
        check("midcalc mul_a", 64'(mul_a), 64'hF);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst out_p", 64'(out_p), 64'd0);
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst mul_ab", 64'({mul_a, mul_b}), 64'd0);
        check("async rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn("post-reset", 8'h03, 8'h05, 16'h000F, SKIP ? 2 : 5, 0);

        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] a, b;
            a = rnd_op();
            b = rnd_op();
            run_txn($sformatf("rnd%0d %0h*%0h", n, a, b), a, b, (2*W)'(a) * (2*W)'(b),
                    model_lat(a, b), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
